// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage.
// It generates data-memory strobes and byte enables, checks alignment and
// legality, and returns zero-extended (BU/HU) load results after one wait cycle.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_data_out
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  ld_f3;

  logic        req;
  logic        ld_ok;
  logic        st_ok;
  logic        illegal;
  logic        misaligned;
  logic        fault;
  logic [1:0]  cause;
  logic        rd_go;
  logic        wr_go;
  logic [3:0]  be_raw;
  logic [31:0] ext_data;

  assign mem_addr    = addr;
  assign mem_data_in = store_data;

  // Decode the IDLE-state request: legality, alignment, enables and stall.
  // Reset gates the combinational strobes so nothing leaks out while held.
  always_comb begin
    req        = reset && (state == IDLE) && valid && (mem_read || mem_write) && !flush;
    ld_ok      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    st_ok      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    illegal    = (mem_read && mem_write) || (mem_read && !ld_ok) || (mem_write && !st_ok);
    misaligned = 1'b0;
    be_raw     = 4'b0000;
    case (funct3[1:0])
      2'b00: be_raw = 4'b0001 << addr[1:0];
      2'b01: begin
        misaligned = addr[0];
        be_raw     = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        misaligned = |addr[1:0];
        be_raw     = 4'b1111;
      end
      default: be_raw = 4'b0000;
    endcase
    fault           = req && (illegal || misaligned);
    cause           = illegal ? 2'b11 : (mem_read ? 2'b01 : 2'b10);
    rd_go           = req && mem_read && !fault;
    wr_go           = req && mem_write && !fault;
    mem_read_en     = rd_go;
    mem_write_en    = wr_go;
    mem_byte_enable = (rd_go || wr_go) ? be_raw : 4'b0000;
    stall           = rd_go || (reset && (state == LOAD_WAIT));
  end

  // Zero-extend unsigned loads; memory has already sign-extended signed ones.
  always_comb begin
    ext_data = mem_data_out;
    case (ld_f3)
      3'b100:  ext_data = {24'b0, mem_data_out[7:0]};
      3'b101:  ext_data = {16'b0, mem_data_out[15:0]};
      default: ext_data = mem_data_out;
    endcase
  end

  // State machine plus registered load result and exception pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ld_f3      <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      exc_valid  <= 1'b0;
      exc_cause  <= '0;
      exc_addr   <= '0;
    end else begin
      load_valid <= 1'b0;
      exc_valid  <= fault;
      if (fault) begin
        exc_cause <= cause;
        exc_addr  <= addr;
      end
      case (state)
        IDLE: begin
          if (rd_go) begin
            ld_f3 <= funct3;
            state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          state <= IDLE;
          if (!flush) begin
            load_data  <= ext_data;
            load_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  Single clock; all state updates on posedge clk.
REQ-002 reset  in  1  Asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of clk.
REQ-003 valid  in  1  MEM-stage instruction present; held stable by pipeline while stall=1.
REQ-004 mem_read / mem_write  in  1 each  Instruction is a load / store.
REQ-005 funct3  in  3  Access width: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-006 addr  in  32  Effective byte address from ALU.
REQ-007 store_data  in  32  rs2 value.
REQ-008 flush  in  1  Abort in-flight load.
REQ-009 stall  out  1  Hold pipeline.
REQ-010 load_data  out  32  Extended load result, registered.
REQ-011 load_valid  out  1  One-cycle pulse, load_data valid.
REQ-012 exc_valid  out  1  One-cycle exception pulse, registered.
REQ-013 exc_cause  out  2  01 load misaligned, 10 store misaligned, 11 illegal access.
REQ-014 exc_addr  out  32  Faulting addr.
REQ-015 mem_addr, mem_data_in  out  32 each  To data memory.
REQ-016 mem_read_en, mem_write_en  out  1 each; mem_byte_enable  out  4.
REQ-017 mem_data_out  in  32  Memory read data, lane-selected and sign-extended by memory, valid the cycle after mem_read_en.

Function
REQ-018 States: IDLE, LOAD_WAIT; 1-bit state register.
REQ-019 mem_addr SHALL equal addr unmodified; mem_data_in SHALL equal store_data unshifted (memory takes low byte/half itself).
REQ-020 mem_byte_enable (IDLE, combinational): B/BU 0001<<addr[1:0]; H/HU 0011 if addr[1]=0, 1100 if addr[1]=1; W 1111.
REQ-021 Alignment: H/HU/SH fault if addr[0]=1; W fault if addr[1:0]!=00; B never faults.
REQ-022 Illegal: mem_read&mem_write both 1, load funct3 in {011,110,111}, store funct3 not in {000,001,010}; cause 11.
REQ-023 Aligned store in IDLE: mem_write_en=1 same cycle, stall=0, no state change; single-cycle.
REQ-024 Aligned load in IDLE (cycle 0): mem_read_en=1, stall=1, latch funct3 into ld_f3, go LOAD_WAIT.
REQ-025 LOAD_WAIT (cycle 1): mem_read_en=0, mem_write_en=0, stall=1; on posedge: load_data <= extend(mem_data_out), load_valid<=1, go IDLE.
REQ-026 Extension by ld_f3: B/H/W pass mem_data_out; BU {24'b0,[7:0]}; HU {16'b0,[15:0]}.
REQ-027 Load latency: load_valid high in cycle 2, exactly one cycle; stall low in cycle 2.
REQ-028 Faulting access: no memory enable asserted, stall=0; next cycle exc_valid=1 one cycle with exc_cause, exc_addr.
REQ-029 valid=0 or neither read nor write: all mem enables 0, stall=0, no pulse.
REQ-030 Requests arriving in LOAD_WAIT SHALL be ignored (pipeline is stalled).
REQ-031 flush in IDLE: suppress any access and exception that cycle; flush in LOAD_WAIT: go IDLE, load_valid stays 0, stall drops next cycle.
REQ-032 load_data SHALL hold its last value when load_valid=0.

Reset
REQ-033 While reset=0: state IDLE, load_data=0, load_valid=0, exc_valid=0, exc_cause=00, exc_addr=0, ld_f3=000.
REQ-034 Reset asserted during LOAD_WAIT aborts load; no load_valid after release.
REQ-035 While reset=0, mem_read_en, mem_write_en, stall SHALL be 0.

Verification
REQ-036 SW addr 0x100 data 0xDEADBEEF -> same cycle mem_write_en=1, be=1111, stall=0; memory word 0x100 = 0xDEADBEEF.
REQ-037 SB addr 0x103 data 0x000000AA -> be=1000, mem_data_in=0x000000AA; LBU 0x103 -> cycle 2 load_valid, load_data=0x000000AA; LB 0x103 -> 0xFFFFFFAA.
REQ-038 LHU addr 0x102 with memory word 0x80010000 -> be=1100, load_data=0x00008001; LH -> 0xFFFF8001; stall high cycles 0-1 only.
REQ-039 LW addr 0x102 -> no mem_read_en, next cycle exc_valid=1, cause 01, exc_addr=0x102; SH addr 0x101 -> cause 10.
REQ-040 Load issued, flush=1 in cycle 1 -> no load_valid, stall=0 in cycle 2; reset pulsed in cycle 1 -> all outputs 0 immediately.
REQ-041 mem_read=mem_write=1, funct3=010 -> no enables, exc_valid next cycle, cause 11.
